// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX pin between the cpu and debug byte sources.
// A requester that wins arbitration keeps the lock until it sends a byte marked
// last (or goes quiet for LOCK_TIMEOUT idle cycles); each accepted byte is sent
// as an 8N1 frame with DIVISOR clocks per bit.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int DIVISOR      = 868,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_valid,
    input  logic [7:0] cpu_data,
    input  logic       cpu_last,
    output logic       cpu_ready,
    input  logic       dbg_valid,
    input  logic [7:0] dbg_data,
    input  logic       dbg_last,
    output logic       dbg_ready,
    input  logic       dbg_prio,
    output logic       tx,
    output logic       busy,
    output logic [1:0] owner
);

    localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       shift;
    logic             pkt_last;
    logic             rr_prefer_dbg;
    logic             grant_cpu;
    logic             grant_dbg;
    logic             bit_end;

    assign bit_end = (div_cnt == DIV_LAST);

    // Pick this cycle's winner: a lock holder is served exclusively, otherwise
    // debug priority first, then round-robin on a tie.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        if (state == IDLE) begin
            case (owner)
                OWN_CPU: grant_cpu = cpu_valid;
                OWN_DBG: grant_dbg = dbg_valid;
                default: begin
                    if (dbg_prio && dbg_valid) begin
                        grant_dbg = 1'b1;
                    end else if (cpu_valid && dbg_valid) begin
                        grant_dbg = rr_prefer_dbg;
                        grant_cpu = !rr_prefer_dbg;
                    end else begin
                        grant_cpu = cpu_valid;
                        grant_dbg = dbg_valid;
                    end
                end
            endcase
        end
    end

    // Transmit FSM with lock tracking; every output is a register, and tx trails
    // the state by one clock so an accept at edge N drops tx at edge N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tx            <= 1'b1;
            busy          <= 1'b0;
            cpu_ready     <= 1'b0;
            dbg_ready     <= 1'b0;
            owner         <= OWN_NONE;
            rr_prefer_dbg <= 1'b0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            to_cnt        <= '0;
            shift         <= '0;
            pkt_last      <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            dbg_ready <= 1'b0;
            to_cnt    <= '0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (grant_cpu || grant_dbg) begin
                        state         <= START;
                        busy          <= 1'b1;
                        shift         <= grant_dbg ? dbg_data : cpu_data;
                        pkt_last      <= grant_dbg ? dbg_last : cpu_last;
                        owner         <= grant_dbg ? OWN_DBG : OWN_CPU;
                        rr_prefer_dbg <= grant_cpu;
                        cpu_ready     <= grant_cpu;
                        dbg_ready     <= grant_dbg;
                        div_cnt       <= '0;
                        bit_cnt       <= '0;
                    end else if (owner != OWN_NONE) begin
                        if (to_cnt == TO_LAST) begin
                            owner <= OWN_NONE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        div_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (bit_end) begin
                        div_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        if (pkt_last) begin
                            owner <= OWN_NONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: drives both byte sources, decodes the tx line back into
// bytes and compares them, in order, against a queue of expected bytes.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int DIV     = 4;
    localparam int LT      = 16;
    localparam int SDIV    = 868;
    localparam int SPACING = 10 * DIV + 1;
    localparam int BOUND   = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     = 1'b0;
    logic       cpu_valid = 1'b0;
    logic [7:0] cpu_data  = 8'h00;
    logic       cpu_last  = 1'b0;
    logic       cpu_ready;
    logic       dbg_valid = 1'b0;
    logic [7:0] dbg_data  = 8'h00;
    logic       dbg_last  = 1'b0;
    logic       dbg_ready;
    logic       dbg_prio  = 1'b0;
    logic       tx;
    logic       busy;
    logic [1:0] owner;

    logic       s_cpu_valid = 1'b0;
    logic [7:0] s_cpu_data  = 8'h00;
    logic       s_cpu_last  = 1'b0;
    logic       s_cpu_ready;
    logic       s_dbg_valid = 1'b0;
    logic [7:0] s_dbg_data  = 8'h00;
    logic       s_dbg_last  = 1'b0;
    logic       s_dbg_ready;
    logic       s_dbg_prio  = 1'b0;
    logic       s_tx;
    logic       s_busy;
    logic [1:0] s_owner;

    uart_tx_arbiter #(.DIVISOR(DIV), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_last(cpu_last), .cpu_ready(cpu_ready),
        .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_last(dbg_last), .dbg_ready(dbg_ready),
        .dbg_prio(dbg_prio), .tx(tx), .busy(busy), .owner(owner)
    );

    uart_tx_arbiter #(.DIVISOR(SDIV), .LOCK_TIMEOUT(4096)) dut_slow (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(s_cpu_valid), .cpu_data(s_cpu_data), .cpu_last(s_cpu_last), .cpu_ready(s_cpu_ready),
        .dbg_valid(s_dbg_valid), .dbg_data(s_dbg_data), .dbg_last(s_dbg_last), .dbg_ready(s_dbg_ready),
        .dbg_prio(s_dbg_prio), .tx(s_tx), .busy(s_busy), .owner(s_owner)
    );

    typedef struct {
        logic [7:0] data;
        bit         ok;
        int         start;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Ready pulse counters and back-to-back pulse detection.
    int   cpu_pulses = 0;
    int   dbg_pulses = 0;
    int   s_pulses   = 0;
    int   consec     = 0;
    logic prev_c     = 1'b0;
    logic prev_d     = 1'b0;
    always @(negedge clk) begin
        if (cpu_ready === 1'b1) cpu_pulses++;
        if (dbg_ready === 1'b1) dbg_pulses++;
        if (s_cpu_ready === 1'b1) s_pulses++;
        if ((cpu_ready === 1'b1 && prev_c === 1'b1) || (dbg_ready === 1'b1 && prev_d === 1'b1)) consec++;
        prev_c = cpu_ready;
        prev_d = dbg_ready;
    end

    // UART receiver for the fast instance: every sample inside a bit must match
    // the first one, start must be low and stop high, else the frame is not ok.
    bit         rx_busy = 1'b0;
    int         rx_cnt, rx_bit, rx_ph, rx_start;
    logic       rx_ref;
    bit         rx_ok;
    logic [7:0] rx_shift;
    rx_t        rx_item;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy  = 1'b1;
                rx_cnt   = 0;
                rx_ref   = 1'b0;
                rx_ok    = 1'b1;
                rx_shift = 8'h00;
                rx_start = cyc;
            end
        end else begin
            rx_cnt++;
            rx_bit = rx_cnt / DIV;
            rx_ph  = rx_cnt % DIV;
            if (rx_ph == 0) rx_ref = tx;
            else if (tx !== rx_ref) rx_ok = 1'b0;
            if (rx_ph == DIV / 2) begin
                if (rx_bit == 0) begin
                    if (tx !== 1'b0) rx_ok = 1'b0;
                end else if (rx_bit <= 8) begin
                    rx_shift = {tx, rx_shift[7:1]};
                end else begin
                    if (tx !== 1'b1) rx_ok = 1'b0;
                    rx_item.data  = rx_shift;
                    rx_item.ok    = rx_ok;
                    rx_item.start = rx_start;
                    rx_q.push_back(rx_item);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    task automatic cpu_send(input logic [7:0] d, input logic l, output int acc);
        cpu_valid = 1'b1; cpu_data = d; cpu_last = l; acc = -1;
        for (int k = 0; k < BOUND; k++) begin
            @(negedge clk);
            if (cpu_ready === 1'b1) begin acc = cyc; break; end
        end
        cpu_valid = 1'b0;
    endtask

    task automatic dbg_send(input logic [7:0] d, input logic l, output int acc);
        dbg_valid = 1'b1; dbg_data = d; dbg_last = l; acc = -1;
        for (int k = 0; k < BOUND; k++) begin
            @(negedge clk);
            if (dbg_ready === 1'b1) begin acc = cyc; break; end
        end
        dbg_valid = 1'b0;
    endtask

    task automatic wait_rx(output rx_t r, output bit got);
        got = 1'b0;
        r.data = 8'hxx; r.ok = 1'b0; r.start = -1;
        for (int k = 0; k < BOUND; k++) begin
            if (rx_q.size() > 0) begin r = rx_q.pop_front(); got = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit got);
        got = 1'b0;
        for (int k = 0; k < BOUND; k++) begin
            if (busy === 1'b0) begin got = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (tx !== 1'b1) begin fails++; $display("[TB] FAIL reset tx: got %b, expected 1", tx); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset busy: got %b, expected 0", busy); end
        tests++; if (cpu_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset cpu_ready: got %b, expected 0", cpu_ready); end
        tests++; if (dbg_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset dbg_ready: got %b, expected 0", dbg_ready); end
        tests++; if (owner !== 2'b00) begin fails++; $display("[TB] FAIL reset owner: got %b, expected 00", owner); end
        tests++; if (s_tx !== 1'b1) begin fails++; $display("[TB] FAIL reset slow tx: got %b, expected 1", s_tx); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int acc, p0; rx_t r; bit got; logic [7:0] e;
        p0 = cpu_pulses;
        exp_q.push_back(8'h37);
        cpu_send(8'h37, 1'b1, acc);
        tests++; if (acc < 0) begin fails++; $display("[TB] FAIL single accept: got timeout, expected cpu_ready"); end
        tests++; if (owner !== 2'b01) begin fails++; $display("[TB] FAIL single owner in frame: got %b, expected 01", owner); end
        tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL single busy: got %b, expected 1", busy); end
        wait_rx(r, got); e = exp_q.pop_front();
        tests++; if (!got || r.data !== e || !r.ok) begin fails++; $display("[TB] FAIL single frame: got %h ok=%0b, expected %h ok=1", r.data, r.ok, e); end
        tests++; if (r.start - acc !== 1) begin fails++; $display("[TB] FAIL tx fall latency: got %0d, expected 1", r.start - acc); end
        wait_idle(got);
        tests++; if (!got || owner !== 2'b00) begin fails++; $display("[TB] FAIL single owner after: got %b, expected 00", owner); end
        tests++; if (cpu_pulses - p0 !== 1) begin fails++; $display("[TB] FAIL single ready pulses: got %0d, expected 1", cpu_pulses - p0); end
    endtask

    task automatic test_slow_frame();
        int lowcnt, p0; logic [7:0] got_byte; logic stop_bit; bit seen;
        p0 = s_pulses;
        s_cpu_data = 8'h37; s_cpu_last = 1'b1; s_cpu_valid = 1'b1; seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (s_cpu_ready === 1'b1) begin seen = 1'b1; break; end
        end
        s_cpu_valid = 1'b0;
        tests++; if (!seen) begin fails++; $display("[TB] FAIL slow accept: got timeout, expected ready"); end
        tests++; if (s_owner !== 2'b01) begin fails++; $display("[TB] FAIL slow owner in frame: got %b, expected 01", s_owner); end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (s_tx === 1'b0) begin seen = 1'b1; break; end
        end
        tests++; if (!seen) begin fails++; $display("[TB] FAIL slow start bit: got no falling edge, expected tx low"); end
        lowcnt = 0;
        while (s_tx === 1'b0 && lowcnt < 2000) begin lowcnt++; @(negedge clk); end
        tests++; if (lowcnt !== SDIV) begin fails++; $display("[TB] FAIL slow start width: got %0d, expected %0d", lowcnt, SDIV); end
        got_byte = 8'h00;
        for (int i = 0; i < 8; i++) begin
            repeat (SDIV / 2) @(negedge clk);
            got_byte = {s_tx, got_byte[7:1]};
            repeat (SDIV - SDIV / 2) @(negedge clk);
        end
        repeat (SDIV / 2) @(negedge clk);
        stop_bit = s_tx;
        tests++; if (got_byte !== 8'h37) begin fails++; $display("[TB] FAIL slow data: got %h, expected 37", got_byte); end
        tests++; if (stop_bit !== 1'b1) begin fails++; $display("[TB] FAIL slow stop bit: got %b, expected 1", stop_bit); end
        tests++; if (s_owner !== 2'b01) begin fails++; $display("[TB] FAIL slow owner at stop: got %b, expected 01", s_owner); end
        for (int k = 0; k < 1000 && s_busy !== 1'b0; k++) @(negedge clk);
        tests++; if (s_busy !== 1'b0 || s_owner !== 2'b00) begin fails++; $display("[TB] FAIL slow owner after: got %b busy=%b, expected 00 busy=0", s_owner, s_busy); end
        tests++; if (s_pulses - p0 !== 1) begin fails++; $display("[TB] FAIL slow ready pulses: got %0d, expected 1", s_pulses - p0); end
    endtask

    task automatic test_packet_lock();
        int a1, a2, a3, d1; rx_t r; bit got; logic [7:0] e;
        dbg_prio = 1'b1;
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3); exp_q.push_back(8'hD1);
        cpu_send(8'hA1, 1'b0, a1);
        fork
            begin cpu_send(8'hA2, 1'b0, a2); cpu_send(8'hA3, 1'b1, a3); end
            dbg_send(8'hD1, 1'b1, d1);
        join
        dbg_prio = 1'b0;
        tests++; if (a2 - a1 !== SPACING) begin fails++; $display("[TB] FAIL lock cpu byte2 spacing: got %0d, expected %0d", a2 - a1, SPACING); end
        tests++; if (a3 - a2 !== SPACING) begin fails++; $display("[TB] FAIL lock cpu byte3 spacing: got %0d, expected %0d", a3 - a2, SPACING); end
        tests++; if (d1 - a3 !== SPACING) begin fails++; $display("[TB] FAIL lock dbg after packet: got %0d, expected %0d", d1 - a3, SPACING); end
        for (int i = 0; i < 4; i++) begin
            wait_rx(r, got); e = exp_q.pop_front();
            tests++; if (!got || r.data !== e || !r.ok) begin fails++; $display("[TB] FAIL lock frame %0d: got %h ok=%0b, expected %h ok=1", i, r.data, r.ok, e); end
        end
        wait_idle(got);
    endtask

    task automatic test_round_robin();
        int c1, c2, e1, e2; rx_t r; bit got; logic [7:0] e;
        exp_q.push_back(8'hB1); exp_q.push_back(8'hE1); exp_q.push_back(8'hB2); exp_q.push_back(8'hE2);
        fork
            begin cpu_send(8'hB1, 1'b1, c1); cpu_send(8'hB2, 1'b1, c2); end
            begin dbg_send(8'hE1, 1'b1, e1); dbg_send(8'hE2, 1'b1, e2); end
        join
        tests++; if (e1 - c1 !== SPACING) begin fails++; $display("[TB] FAIL rr dbg1 after cpu1: got %0d, expected %0d", e1 - c1, SPACING); end
        tests++; if (c2 - e1 !== SPACING) begin fails++; $display("[TB] FAIL rr cpu2 after dbg1: got %0d, expected %0d", c2 - e1, SPACING); end
        tests++; if (e2 - c2 !== SPACING) begin fails++; $display("[TB] FAIL rr dbg2 after cpu2: got %0d, expected %0d", e2 - c2, SPACING); end
        for (int i = 0; i < 4; i++) begin
            wait_rx(r, got); e = exp_q.pop_front();
            tests++; if (!got || r.data !== e || !r.ok) begin fails++; $display("[TB] FAIL rr frame %0d: got %h ok=%0b, expected %h ok=1", i, r.data, r.ok, e); end
        end
        wait_idle(got);
    endtask

    task automatic test_lock_timeout();
        int c, d, dp0; logic [1:0] own_mid; int dbg_mid; rx_t r; bit got; logic [7:0] e;
        exp_q.push_back(8'hF1); exp_q.push_back(8'hE7);
        cpu_send(8'hF1, 1'b0, c);
        dp0 = dbg_pulses;
        fork
            dbg_send(8'hE7, 1'b1, d);
            begin repeat (50) @(negedge clk); own_mid = owner; dbg_mid = dbg_pulses - dp0; end
        join
        tests++; if (own_mid !== 2'b01) begin fails++; $display("[TB] FAIL timeout owner held: got %b, expected 01", own_mid); end
        tests++; if (dbg_mid !== 0) begin fails++; $display("[TB] FAIL timeout early dbg grant: got %0d, expected 0", dbg_mid); end
        tests++; if (d - c !== 10 * DIV + LT + 1) begin fails++; $display("[TB] FAIL timeout dbg accept: got %0d, expected %0d", d - c, 10 * DIV + LT + 1); end
        for (int i = 0; i < 2; i++) begin
            wait_rx(r, got); e = exp_q.pop_front();
            tests++; if (!got || r.data !== e || !r.ok) begin fails++; $display("[TB] FAIL timeout frame %0d: got %h ok=%0b, expected %h ok=1", i, r.data, r.ok, e); end
        end
        wait_idle(got);
        tests++; if (!got || owner !== 2'b00) begin fails++; $display("[TB] FAIL timeout owner after: got %b, expected 00", owner); end
    endtask

    task automatic test_reset_mid_frame();
        int c, c2; rx_t r; bit got; logic [7:0] e;
        cpu_send(8'hA5, 1'b0, c);
        repeat (17) @(negedge clk);
        tests++; if (tx !== 1'b0) begin fails++; $display("[TB] FAIL pre-reset bit3: got %b, expected 0", tx); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (tx !== 1'b1) begin fails++; $display("[TB] FAIL async reset tx: got %b, expected 1", tx); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL async reset busy: got %b, expected 0", busy); end
        tests++; if (owner !== 2'b00) begin fails++; $display("[TB] FAIL async reset owner: got %b, expected 00", owner); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'hC3);
        cpu_send(8'hC3, 1'b1, c2);
        wait_rx(r, got); e = exp_q.pop_front();
        tests++; if (!got || r.data !== e || !r.ok) begin fails++; $display("[TB] FAIL post-reset frame: got %h ok=%0b, expected %h ok=1", r.data, r.ok, e); end
        tests++; if (r.start - c2 !== 1) begin fails++; $display("[TB] FAIL post-reset latency: got %0d, expected 1", r.start - c2); end
        wait_idle(got);
    endtask

    task automatic test_back_to_back();
        int s1, s2, s3, cons0; rx_t r; bit got; logic [7:0] e;
        cons0 = consec;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        cpu_send(8'h00, 1'b1, s1);
        cpu_send(8'hFF, 1'b1, s2);
        cpu_send(8'h55, 1'b1, s3);
        tests++; if (s2 - s1 !== SPACING) begin fails++; $display("[TB] FAIL b2b spacing 1: got %0d, expected %0d", s2 - s1, SPACING); end
        tests++; if (s3 - s2 !== SPACING) begin fails++; $display("[TB] FAIL b2b spacing 2: got %0d, expected %0d", s3 - s2, SPACING); end
        for (int i = 0; i < 3; i++) begin
            wait_rx(r, got); e = exp_q.pop_front();
            tests++; if (!got || r.data !== e || !r.ok) begin fails++; $display("[TB] FAIL b2b frame %0d: got %h ok=%0b, expected %h ok=1", i, r.data, r.ok, e); end
        end
        tests++; if (consec !== cons0) begin fails++; $display("[TB] FAIL ready consecutive: got %0d, expected %0d", consec, cons0); end
        wait_idle(got);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_slow_frame();
        test_packet_lock();
        test_round_robin();
        test_lock_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (60) @(negedge clk);
        tests++; if (rx_q.size() !== 0) begin fails++; $display("[TB] FAIL stray frames: got %0d, expected 0", rx_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
